// File: rtl/dsm_decimator_pkg.sv
// Shared constants for the 1-bit delta-sigma audio path (chime DAC and loopback decoder).
package dsm_decimator_pkg;

  // log2 of the decimation / oversampling ratio used across the audio path
  localparam int LOG2R_DEF = 6;

  // Square of the ratio for a given log2 ratio; this is the CIC DC gain
  function automatic int r_sq(input int log2r);
    return 1 << (2 * log2r);
  endfunction

  localparam int R_SQ = r_sq(LOG2R_DEF);

  // Start-up priming: the comb delay lines hold garbage until two events have passed
  typedef enum logic [1:0] {
    PRIME_NONE = 2'd0,
    PRIME_ONE  = 2'd1,
    PRIME_DONE = 2'd2
  } prime_e;

endpackage

// File: rtl/dsm_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module dsm_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the input to settle metastability before use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dsm_decimator.sv
// Second-order CIC decimator: 1-bit DSM stream in, saturated unsigned PCM out.
module dsm_decimator
  import dsm_decimator_pkg::*;
#(
  parameter  int LOG2R = LOG2R_DEF,
  localparam int OUT_W = 2 * LOG2R,
  localparam int ACC_W = 2 * LOG2R + 1
) (
  input  logic             CK_i,
  input  logic             XARST_i,
  input  logic             CKE_i,
  input  logic             DSM_i,
  input  logic             CLR_i,
  output logic [OUT_W-1:0] PCM_o,
  output logic             VALID_o,
  output logic             CLIP_o
);

  // Full-scale DC output; c2 reaches this only for an all-ones window
  localparam logic [ACC_W-1:0] SAT_LIM = ACC_W'(r_sq(LOG2R));

  logic             ds;
  logic [ACC_W-1:0] i1, i2;
  logic [ACC_W-1:0] d1, d2;
  logic [ACC_W-1:0] c1_p0, c2_p0;
  logic [LOG2R-1:0] phase;
  prime_e           prime;
  logic             evt_p0;
  logic             primed_p0;
  logic             sat_p0;

  // Clamp the comb result into the unsigned PCM range
  function automatic logic [OUT_W-1:0] clamp_pcm(input logic [ACC_W-1:0] v);
    if (v >= SAT_LIM) return '1;
    else              return v[OUT_W-1:0];
  endfunction

  dsm_sync2 u_sync (
    .clk   (CK_i),
    .rst_n (XARST_i),
    .d     (DSM_i),
    .q     (ds)
  );

  // Stage p0: decimation event and combs on the pre-update integrator value
  assign evt_p0    = CKE_i && (phase == '1);
  assign primed_p0 = (prime == PRIME_DONE);
  assign c1_p0     = i2 - d1;
  assign c2_p0     = c1_p0 - d2;
  assign sat_p0    = (c2_p0 >= SAT_LIM);

  // Integrators and phase counter advance once per consumed DSM bit; wrap is harmless
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      i1    <= '0;
      i2    <= '0;
      phase <= '0;
    end else if (CKE_i) begin
      i1    <= i1 + ACC_W'(ds);
      i2    <= i2 + i1;
      phase <= phase + 1'b1;
    end
  end

  // Comb delay lines and priming counter update on each decimation event
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      d1    <= '0;
      d2    <= '0;
      prime <= PRIME_NONE;
    end else if (evt_p0) begin
      d1 <= i2;
      d2 <= c1_p0;
      case (prime)
        PRIME_NONE: prime <= PRIME_ONE;
        PRIME_ONE:  prime <= PRIME_DONE;
        default:    prime <= PRIME_DONE;
      endcase
    end
  end

  // Stage p1: registered PCM, valid strobe and sticky clip flag (set beats clear)
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      PCM_o   <= '0;
      VALID_o <= 1'b0;
      CLIP_o  <= 1'b0;
    end else begin
      VALID_o <= evt_p0 && primed_p0;
      if (evt_p0) PCM_o <= clamp_pcm(c2_p0);
      if (evt_p0 && primed_p0 && sat_p0) CLIP_o <= 1'b1;
      else if (CLR_i)                    CLIP_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsm_decimator.sv
// Directed bench for dsm_decimator at the default ratio R = 64 (PCM full scale 4095).
module tb_dsm_decimator;

  logic        CK_i = 1'b0;
  logic        XARST_i;
  logic        CKE_i;
  logic        DSM_i;
  logic        CLR_i;
  logic [11:0] PCM_o;
  logic        VALID_o;
  logic        CLIP_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int glitch = 0;
  int          vcyc[$];
  logic [11:0] vval[$];

  dsm_decimator dut (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .CKE_i   (CKE_i),
    .DSM_i   (DSM_i),
    .CLR_i   (CLR_i),
    .PCM_o   (PCM_o),
    .VALID_o (VALID_o),
    .CLIP_o  (CLIP_o)
  );

  always #5 CK_i = ~CK_i;

  task automatic assert_reset();
    XARST_i = 1'b0;
    CKE_i   = 1'b0;
    DSM_i   = 1'b0;
    CLR_i   = 1'b0;
  endtask

  // Hold reset for two edges, release just after an edge; next edge is cycle 1
  task automatic release_reset();
    @(posedge CK_i); @(posedge CK_i); #1;
    XARST_i = 1'b1;
    cyc = 0;
    glitch = 0;
    vcyc.delete();
    vval.delete();
  endtask

  // cke_mode: 0 always enabled, 1 enabled on alternate cycles, 2 disabled.
  // pat bit k is the k-th consumed DSM bit (repeating with period plen).
  task automatic run(input int ncyc, input logic [3:0] pat, input int plen,
                     input int cke_mode, input int clr_at);
    logic [11:0] last;
    bit seen;
    int k;
    last = PCM_o;
    seen = 0;
    for (int n = 0; n < ncyc; n++) begin
      k = (cke_mode == 1) ? n / 2 : n;
      CKE_i = (cke_mode == 0) ? 1'b1 : (cke_mode == 1) ? ((n % 2) == 0) : 1'b0;
      DSM_i = pat[k % plen];
      CLR_i = (n == clr_at);
      @(posedge CK_i); #1;
      cyc++;
      if (VALID_o) begin
        seen = 1;
        vcyc.push_back(cyc);
        vval.push_back(PCM_o);
      end else if (seen && PCM_o !== last) begin
        glitch++;
      end
      last = PCM_o;
    end
    CLR_i = 1'b0;
  endtask

  task automatic test_reset();
    assert_reset();
    #1;
    checks++; if (PCM_o !== 12'd0) begin errors++; $display("FAIL reset_pcm: got %0d want 0", PCM_o); end
    checks++; if (VALID_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", VALID_o); end
    checks++; if (CLIP_o !== 1'b0) begin errors++; $display("FAIL reset_clip: got %b want 0", CLIP_o); end
    release_reset();
  endtask

  task automatic test_saturate();
    assert_reset(); release_reset();
    run(191, 4'b1111, 1, 0, -1);
    checks++; if (vcyc.size() != 0) begin errors++; $display("FAIL prime_no_valid: got %0d strobes want 0", vcyc.size()); end
    checks++; if (CLIP_o !== 1'b0) begin errors++; $display("FAIL prime_no_clip: got %b want 0", CLIP_o); end
    run(193, 4'b1111, 1, 0, -1);
    checks++; if (vcyc.size() != 4) begin errors++; $display("FAIL ones_count: got %0d want 4", vcyc.size()); end
    if (vcyc.size() > 0) begin
      checks++; if (vcyc[0] != 192) begin errors++; $display("FAIL first_valid_cycle: got %0d want 192", vcyc[0]); end
    end
    foreach (vval[i]) begin
      checks++; if (vval[i] !== 12'd4095) begin errors++; $display("FAIL ones_value[%0d]: got %0d want 4095", i, vval[i]); end
    end
    checks++; if (CLIP_o !== 1'b1) begin errors++; $display("FAIL ones_clip: got %b want 1", CLIP_o); end
  endtask

  task automatic test_zeros();
    assert_reset(); release_reset();
    run(384, 4'b0000, 1, 0, -1);
    checks++; if (vcyc.size() != 4) begin errors++; $display("FAIL zeros_count: got %0d want 4", vcyc.size()); end
    foreach (vval[i]) begin
      checks++; if (vval[i] !== 12'd0) begin errors++; $display("FAIL zeros_value[%0d]: got %0d want 0", i, vval[i]); end
    end
    checks++; if (CLIP_o !== 1'b0) begin errors++; $display("FAIL zeros_clip: got %b want 0", CLIP_o); end
  endtask

  task automatic test_density();
    assert_reset(); release_reset();
    run(384, 4'b0001, 2, 0, -1);
    checks++; if (vcyc.size() != 4) begin errors++; $display("FAIL half_count: got %0d want 4", vcyc.size()); end
    foreach (vval[i]) begin
      checks++; if (vval[i] !== 12'd2048) begin errors++; $display("FAIL half_value[%0d]: got %0d want 2048", i, vval[i]); end
    end
    for (int i = 1; i < vcyc.size(); i++) begin
      checks++; if (vcyc[i] - vcyc[i-1] != 64) begin errors++; $display("FAIL half_spacing[%0d]: got %0d want 64", i, vcyc[i] - vcyc[i-1]); end
    end
    assert_reset(); release_reset();
    run(384, 4'b0001, 4, 0, -1);
    checks++; if (vcyc.size() != 4) begin errors++; $display("FAIL quarter_count: got %0d want 4", vcyc.size()); end
    foreach (vval[i]) begin
      checks++; if (vval[i] !== 12'd1024) begin errors++; $display("FAIL quarter_value[%0d]: got %0d want 1024", i, vval[i]); end
    end
  endtask

  task automatic test_cke_toggle();
    logic [11:0] hold;
    int nv;
    assert_reset(); release_reset();
    run(768, 4'b0001, 2, 1, -1);
    checks++; if (vcyc.size() != 4) begin errors++; $display("FAIL cke_count: got %0d want 4", vcyc.size()); end
    if (vcyc.size() > 0) begin
      checks++; if (vcyc[0] != 383) begin errors++; $display("FAIL cke_first_valid: got %0d want 383", vcyc[0]); end
    end
    for (int i = 1; i < vcyc.size(); i++) begin
      checks++; if (vcyc[i] - vcyc[i-1] != 128) begin errors++; $display("FAIL cke_spacing[%0d]: got %0d want 128", i, vcyc[i] - vcyc[i-1]); end
    end
    foreach (vval[i]) begin
      checks++; if (vval[i] !== 12'd2048) begin errors++; $display("FAIL cke_value[%0d]: got %0d want 2048", i, vval[i]); end
    end
    checks++; if (glitch != 0) begin errors++; $display("FAIL cke_pcm_stable: got %0d changes want 0", glitch); end
    hold = PCM_o;
    nv = vcyc.size();
    run(300, 4'b1111, 1, 2, -1);
    checks++; if (vcyc.size() != nv) begin errors++; $display("FAIL cke_off_valid: got %0d strobes want %0d", vcyc.size(), nv); end
    checks++; if (PCM_o !== hold) begin errors++; $display("FAIL cke_off_hold: got %0d want %0d", PCM_o, hold); end
  endtask

  task automatic test_clip_clear();
    assert_reset(); release_reset();
    run(384, 4'b1111, 1, 0, -1);
    checks++; if (CLIP_o !== 1'b1) begin errors++; $display("FAIL clip_set: got %b want 1", CLIP_o); end
    run(12, 4'b0000, 1, 0, 10);
    checks++; if (CLIP_o !== 1'b0) begin errors++; $display("FAIL clip_cleared: got %b want 0", CLIP_o); end
    run(188, 4'b0000, 1, 0, -1);
    checks++; if (CLIP_o !== 1'b0) begin errors++; $display("FAIL clip_stays_clear: got %b want 0", CLIP_o); end
    assert_reset(); release_reset();
    run(256, 4'b1111, 1, 0, 255);
    checks++; if (vcyc.size() != 2) begin errors++; $display("FAIL clip_race_count: got %0d want 2", vcyc.size()); end
    checks++; if (CLIP_o !== 1'b1) begin errors++; $display("FAIL clip_set_wins: got %b want 1", CLIP_o); end
  endtask

  task automatic test_reset_mid();
    assert_reset(); release_reset();
    run(468, 4'b1111, 1, 0, -1);
    checks++; if (vcyc.size() != 5) begin errors++; $display("FAIL mid_pre_count: got %0d want 5", vcyc.size()); end
    #3;
    assert_reset();
    #1;
    checks++; if (PCM_o !== 12'd0) begin errors++; $display("FAIL mid_reset_pcm: got %0d want 0", PCM_o); end
    checks++; if (CLIP_o !== 1'b0) begin errors++; $display("FAIL mid_reset_clip: got %b want 0", CLIP_o); end
    checks++; if (VALID_o !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", VALID_o); end
    release_reset();
    run(8704, 4'b1111, 1, 0, -1);
    checks++; if (vcyc.size() != 134) begin errors++; $display("FAIL wrap_count: got %0d want 134", vcyc.size()); end
    if (vcyc.size() > 0) begin
      checks++; if (vcyc[0] != 192) begin errors++; $display("FAIL reprime_first_valid: got %0d want 192", vcyc[0]); end
    end
    foreach (vval[i]) begin
      checks++; if (vval[i] !== 12'd4095) begin errors++; $display("FAIL wrap_value[%0d]: got %0d want 4095", i, vval[i]); end
    end
    checks++; if (glitch != 0) begin errors++; $display("FAIL wrap_pcm_stable: got %0d changes want 0", glitch); end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_zeros();
    test_density();
    test_cke_toggle();
    test_clip_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
